// File: rtl/pipeline_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel, the decode-side
// valid/ready channel, and the redirect input.
interface pipeline_fetch_queue_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic [ADDR_WIDTH-1:0]  S_R_ADDR;
    logic                   S_R_ADDR_VALID;
    logic                   S_R_ADDR_READY;
    logic [INSTR_WIDTH-1:0] S_R_DATA;
    logic                   S_R_DATA_VALID;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0]  next_stage_pc;
    logic                   instr_valid;
    logic                   instr_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output S_R_ADDR, S_R_ADDR_VALID,
        input  S_R_ADDR_READY, S_R_DATA, S_R_DATA_VALID,
        output instruction, next_stage_pc, instr_valid,
        input  instr_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  S_R_ADDR, S_R_ADDR_VALID,
        output S_R_ADDR_READY, S_R_DATA, S_R_DATA_VALID,
        input  instruction, next_stage_pc, instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/pipeline_fetch_queue.sv
// Instruction fetch stage: sequential PC generator with credit-limited prefetch queue.
// A redirect clears the queue and discards responses to requests issued before it.
module pipeline_fetch_queue #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
    input logic                     clk,
    input logic                     reset,
    pipeline_fetch_queue_if.master  bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INSTR_WIDTH / 8);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(QUEUE_DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);
    localparam logic [PW-1:0] PZERO_C = {PW{1'b0}};

    typedef enum logic [0:0] {FETCH = 1'b0, FLUSH = 1'b1} state_t;

    state_t                  state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0]   fetch_pc_r;
    logic [CW-1:0]           count_r, outstanding_r, drop_r;
    logic [CW-1:0]           outstanding_nxt_s, drop_nxt_s;
    logic [PW-1:0]           q_head_r, q_tail_r, pcf_head_r, pcf_tail_r;
    logic [ADDR_WIDTH-1:0]   q_pc_r   [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0]  q_data_r [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]   pcf_r    [QUEUE_DEPTH];
    logic                    fetching_s, addr_valid_s, accept_s;
    logic                    push_s, pop_s, instr_valid_s;
    logic [ADDR_WIDTH-1:0]   resp_pc_s;

    // Handshake decode; requests only while queued plus in-flight stays below depth
    always_comb begin
        fetching_s    = !reset && (state_r == FETCH);
        addr_valid_s  = fetching_s && (({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_C);
        accept_s      = addr_valid_s && bus.S_R_ADDR_READY;
        instr_valid_s = fetching_s && (count_r != ZERO_C);
        pop_s         = instr_valid_s && bus.instr_ready;
        push_s        = bus.S_R_DATA_VALID && (drop_r == ZERO_C) && !bus.redirect_valid;
        // With nothing in flight a response can only belong to this cycle's request
        resp_pc_s     = (outstanding_r == ZERO_C) ? fetch_pc_r : pcf_r[pcf_head_r];
        outstanding_nxt_s = outstanding_r + (accept_s ? ONE_C : ZERO_C)
                            - (bus.S_R_DATA_VALID ? ONE_C : ZERO_C);
    end

    // Next-state and drop-count logic; redirect overrides everything
    always_comb begin
        state_nxt_s = state_r;
        drop_nxt_s  = drop_r;
        if (bus.S_R_DATA_VALID && (drop_r != ZERO_C)) begin
            drop_nxt_s = drop_r - ONE_C;
        end else begin
            drop_nxt_s = drop_r;
        end
        if (bus.redirect_valid) begin
            drop_nxt_s  = outstanding_nxt_s;
            state_nxt_s = (outstanding_nxt_s != ZERO_C) ? FLUSH : FETCH;
        end else begin
            case (state_r)
                FETCH:   state_nxt_s = FETCH;
                FLUSH:   state_nxt_s = (drop_nxt_s == ZERO_C) ? FETCH : FLUSH;
                default: state_nxt_s = FETCH;
            endcase
        end
    end

    // Control registers: state, PC, counters and queue pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= FETCH;
            fetch_pc_r    <= RESET_PC;
            count_r       <= ZERO_C;
            outstanding_r <= ZERO_C;
            drop_r        <= ZERO_C;
            q_head_r      <= PZERO_C;
            q_tail_r      <= PZERO_C;
            pcf_head_r    <= PZERO_C;
            pcf_tail_r    <= PZERO_C;
        end else begin
            state_r       <= state_nxt_s;
            drop_r        <= drop_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            if (bus.redirect_valid) begin
                fetch_pc_r <= bus.redirect_pc;
            end else if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end
            if (accept_s) begin
                pcf_tail_r <= pcf_tail_r + PONE_C;
            end
            if (bus.S_R_DATA_VALID) begin
                pcf_head_r <= pcf_head_r + PONE_C;
            end
            if (bus.redirect_valid) begin
                count_r  <= ZERO_C;
                q_head_r <= PZERO_C;
                q_tail_r <= PZERO_C;
            end else begin
                if (push_s) begin
                    q_tail_r <= q_tail_r + PONE_C;
                end
                if (pop_s) begin
                    q_head_r <= q_head_r + PONE_C;
                end
                count_r <= count_r + (push_s ? ONE_C : ZERO_C) - (pop_s ? ONE_C : ZERO_C);
            end
        end
    end

    // Storage for the pc-in-flight FIFO and the instruction queue
    always_ff @(posedge clk) begin
        if (accept_s) begin
            pcf_r[pcf_tail_r] <= fetch_pc_r;
        end
        if (push_s) begin
            q_pc_r[q_tail_r]   <= resp_pc_s;
            q_data_r[q_tail_r] <= bus.S_R_DATA;
        end
    end

    assign bus.S_R_ADDR       = fetch_pc_r;
    assign bus.S_R_ADDR_VALID = addr_valid_s;
    assign bus.instr_valid    = instr_valid_s;
    assign bus.instruction    = instr_valid_s ? q_data_r[q_head_r] : {INSTR_WIDTH{1'b0}};
    assign bus.next_stage_pc  = instr_valid_s ? q_pc_r[q_head_r] : {ADDR_WIDTH{1'b0}};
endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Randomised bench for pipeline_fetch_queue with a queue-level reference model,
// a scripted memory responder and a few hand-computed anchor checks.
module tb_pipeline_fetch_queue;
    localparam int AW = 64;
    localparam int IW = 32;
    localparam int D  = 4;
    localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef struct {logic [63:0] pc; logic [31:0] data;} ent_t;
    typedef struct {int rc; logic [63:0] addr;} mreq_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_fetch_queue_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();
    pipeline_fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .QUEUE_DEPTH(D), .RESET_PC(RPC))
        dut (.clk(clk), .reset(reset), .bus(bus));

    ent_t        m_q[$];
    logic [63:0] m_infl[$];
    logic [63:0] m_pc;
    int          m_drop;
    mreq_t       mem_q[$];
    logic [63:0] acc_log[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_F00D;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_infl.delete();
        mem_q.delete();
        m_pc   = RPC;
        m_drop = 0;
    endtask

    // One clock: compare outputs against the model, drive inputs, advance model and memory
    task automatic step(input logic rv, input logic [63:0] rpc, input logic ar,
                        input logic ir, input int mm);
        bit exp_av, exp_iv, acc, resp, pop;
        logic [63:0] rp;
        mreq_t r;
        ent_t e;
        @(negedge clk);
        exp_av = (m_drop == 0) && ((m_q.size() + m_infl.size()) < D);
        exp_iv = (m_drop == 0) && (m_q.size() > 0);
        chk("addr_valid", 64'(bus.S_R_ADDR_VALID), 64'(exp_av));
        if (exp_av) chk("addr", bus.S_R_ADDR, m_pc);
        chk("instr_valid", 64'(bus.instr_valid), 64'(exp_iv));
        chk("next_stage_pc", bus.next_stage_pc, exp_iv ? m_q[0].pc : 64'd0);
        chk("instruction", 64'(bus.instruction), exp_iv ? 64'(m_q[0].data) : 64'd0);

        resp = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].rc <= cyc) begin
            if (mm == 1 || (mm == 2 && $urandom_range(99) < 60)) resp = 1'b1;
        end
        bus.S_R_DATA_VALID = resp;
        if (resp) begin
            r = mem_q.pop_front();
            bus.S_R_DATA = mem_data(r.addr);
        end else begin
            bus.S_R_DATA = $urandom;
        end
        bus.S_R_ADDR_READY = ar;
        bus.instr_ready    = ir;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        if (bus.S_R_ADDR_VALID && ar) begin
            r.rc   = cyc + 1 + ((mm == 2) ? int'($urandom_range(3)) : 0);
            r.addr = bus.S_R_ADDR;
            mem_q.push_back(r);
            acc_log.push_back(bus.S_R_ADDR);
        end

        acc = exp_av && ar;
        pop = exp_iv && ir;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            m_infl.push_back(m_pc);
            m_pc = m_pc + 64'd4;
        end
        if (resp) begin
            rp = (m_infl.size() > 0) ? m_infl.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            if (m_drop > 0) begin
                m_drop--;
            end else if (!rv) begin
                e.pc   = rp;
                e.data = mem_data(rp);
                m_q.push_back(e);
            end
        end
        if (rv) begin
            m_q.delete();
            m_pc   = rpc;
            m_drop = m_infl.size();
        end
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.S_R_ADDR_READY = 1'b0;
        bus.S_R_DATA       = 32'd0;
        bus.S_R_DATA_VALID = 1'b0;
        bus.instr_ready    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("rst_addr_valid", 64'(bus.S_R_ADDR_VALID), 64'd0);
        chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_instruction", 64'(bus.instruction), 64'd0);
        chk("rst_pc", bus.next_stage_pc, 64'd0);
        model_reset();
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] rpc;
        logic [31:0] lo;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_addr_valid", 64'(bus.S_R_ADDR_VALID), 64'd0);
        chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        chk("rst_instruction", 64'(bus.instruction), 64'd0);
        chk("rst_pc", bus.next_stage_pc, 64'd0);
        reset = 1'b0;

        // Wrap and credit limit: decode stalled, memory always ready, 1-cycle latency
        repeat (6) step(1'b0, 64'd0, 1'b1, 1'b0, 1);
        chk("acc_count", 64'(acc_log.size()), 64'd4);
        if (acc_log.size() >= 4) begin
            chk("acc0", acc_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("acc1_wrap", acc_log[1], 64'h0);
            chk("acc2", acc_log[2], 64'h4);
            chk("acc3", acc_log[3], 64'h8);
        end
        chk("credit_stop", 64'(bus.S_R_ADDR_VALID), 64'd0);
        chk("head_pc", bus.next_stage_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("head_instr", 64'(bus.instruction), 64'hA5A5_0FF1);
        step(1'b0, 64'd0, 1'b1, 1'b1, 1);
        step(1'b0, 64'd0, 1'b1, 1'b0, 1);
        chk("second_pc", bus.next_stage_pc, 64'h0);
        chk("second_instr", 64'(bus.instruction), 64'h5A5A_F00D);
        chk("refill_addr", bus.S_R_ADDR, 64'hC);

        // Memory not ready while draining: address must hold
        repeat (10) step(1'b0, 64'd0, 1'b0, 1'b1, 1);
        chk("hold_valid", 64'(bus.S_R_ADDR_VALID), 64'd1);
        chk("hold_addr", bus.S_R_ADDR, 64'h10);

        // Three in flight, then redirect to 0x100
        repeat (3) step(1'b0, 64'd0, 1'b1, 1'b1, 0);
        step(1'b1, 64'h100, 1'b0, 1'b1, 0);
        step(1'b0, 64'd0, 1'b1, 1'b1, 1);
        chk("flush_addr_valid", 64'(bus.S_R_ADDR_VALID), 64'd0);
        chk("flush_instr_valid", 64'(bus.instr_valid), 64'd0);
        repeat (3) step(1'b0, 64'd0, 1'b1, 1'b1, 1);
        chk("post_flush_valid", 64'(bus.S_R_ADDR_VALID), 64'd1);
        chk("post_flush_addr", bus.S_R_ADDR, 64'h100);
        repeat (2) step(1'b0, 64'd0, 1'b0, 1'b0, 1);
        chk("redir_pc", bus.next_stage_pc, 64'h100);
        chk("redir_instr", 64'(bus.instruction), 64'h5A5A_F10D);

        // Redirect with nothing outstanding goes straight back to fetching
        repeat (6) step(1'b0, 64'd0, 1'b0, 1'b1, 1);
        step(1'b1, 64'h2000, 1'b0, 1'b0, 1);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1);
        chk("nz_redir_valid", 64'(bus.S_R_ADDR_VALID), 64'd1);
        chk("nz_redir_addr", bus.S_R_ADDR, 64'h2000);

        // Random traffic, including redirects in flight and one mid-run reset
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            lo  = $urandom;
            rpc = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                           : {32'($urandom), lo[31:2], 2'b00};
            step(($urandom_range(39) == 0), rpc, ($urandom_range(99) < 70),
                 ($urandom_range(99) < 60), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
